// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// Imported by the control top, its immediate generator and the memory interface users.
package multicycle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] PC_SRC_PC4 = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_ALU = 2'd2;

    localparam logic [1:0] SRC_A_RS1   = 2'd0;
    localparam logic [1:0] SRC_A_OLDPC = 2'd1;
    localparam logic [1:0] SRC_A_PC    = 2'd2;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_CMP   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // The extended branch compares are only legal when the core builds them.
    function automatic logic br_f3_ok(input logic [2:0] f3, input logic ext);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_BEQ, F3_BNE, F3_BLT:   ok = 1'b1;
            F3_BGE, F3_BLTU, F3_BGEU: ok = ext;
            default:                  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Shared instruction/data memory handshake.
// The control unit is the master; the memory answers with mem_ready.
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control_imm_gen.sv
// Combinational immediate extractor for I/S/B/J formats.
// R-type and unknown opcodes yield zero.
module imm_gen
    import multicycle_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm
);

    // Select and sign-extend the immediate field for the opcode format.
    always_comb begin
        imm = '0;
        unique case (inst[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
            OP_STORE:
                imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            OP_BRANCH:
                imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7],
                       inst[30:25], inst[11:8], 1'b0};
            OP_JAL:
                imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12],
                       inst[20], inst[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing,
// datapath strobes, sticky illegal and memory-timeout traps.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int TIMEOUT    = 255,
    parameter int BRANCH_EXT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_control_if.master  mem,
    input  logic [31:0]           inst,
    input  logic                  alu_zero,
    input  logic                  alu_lt,
    input  logic                  alu_ltu,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic [1:0]            pc_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            aluop,
    output logic                  reg_write,
    output logic [1:0]            wb_sel,
    output logic [XLEN-1:0]       imm,
    output logic                  illegal,
    output logic                  bus_error,
    output logic [2:0]            state_o
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            illegal_q, illegal_d;
    logic            bus_error_q, bus_error_d;
    logic [XLEN-1:0] imm_raw;

    logic [2:0] funct3;
    logic is_load, is_store, is_branch, is_imm;
    logic is_reg, is_jal, is_jalr;
    logic legal, taken, timed_out, mem_phase;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (inst),
        .imm  (imm_raw)
    );

    assign funct3    = inst[14:12];
    assign is_load   = (inst[6:0] == OP_LOAD);
    assign is_store  = (inst[6:0] == OP_STORE);
    assign is_branch = (inst[6:0] == OP_BRANCH);
    assign is_imm    = (inst[6:0] == OP_IMM);
    assign is_reg    = (inst[6:0] == OP_REG);
    assign is_jal    = (inst[6:0] == OP_JAL);
    assign is_jalr   = (inst[6:0] == OP_JALR);

    assign legal = is_load | is_store | is_imm | is_reg | is_jal | is_jalr
                 | (is_branch & br_f3_ok(funct3, BRANCH_EXT != 0));

    assign mem_phase = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign timed_out = mem_phase && !mem.mem_ready
                    && (cnt_q == CW'(TIMEOUT));

    // Branch outcome from the ALU flags selected by funct3.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = alu_zero;
            F3_BNE:  taken = !alu_zero;
            F3_BLT:  taken = alu_lt;
            F3_BGE:  taken = !alu_lt;
            F3_BLTU: taken = alu_ltu;
            F3_BGEU: taken = !alu_ltu;
            default: taken = 1'b0;
        endcase
    end

    // Next-state, immediate capture, trap flags and wait counter.
    always_comb begin
        state_d     = state_q;
        imm_d       = imm_q;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem.mem_ready) begin
                    state_d = ST_DECODE;
                end else if (timed_out) begin
                    bus_error_d = 1'b1;
                    state_d     = ST_TRAP;
                end
            end
            ST_DECODE: begin
                imm_d = imm_raw;
                if (legal) begin
                    state_d = ST_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end
            end
            ST_EXEC: begin
                if (is_load || is_store) state_d = ST_MEM;
                else if (is_branch)      state_d = ST_FETCH;
                else                     state_d = ST_WB;
            end
            ST_MEM: begin
                if (mem.mem_ready) begin
                    state_d = is_store ? ST_FETCH : ST_WB;
                end else if (timed_out) begin
                    bus_error_d = 1'b1;
                    state_d     = ST_TRAP;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (mem_phase && !mem.mem_ready) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Per-state datapath strobes; everything idles low by default.
    always_comb begin
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_PC4;
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_RS2;
        aluop        = ALUOP_ADD;
        reg_write    = 1'b0;
        wb_sel       = WB_ALU;
        unique case (state_q)
            ST_FETCH: begin
                mem.mem_req = 1'b1;
                alu_src_a   = SRC_A_PC;
                alu_src_b   = SRC_B_FOUR;
                if (mem.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            ST_EXEC: begin
                if (is_reg) begin
                    aluop = ALUOP_RTYPE;
                end else if (is_imm) begin
                    aluop     = ALUOP_ITYPE;
                    alu_src_b = SRC_B_IMM;
                end else if (is_load || is_store) begin
                    alu_src_b = SRC_B_IMM;
                end else if (is_branch) begin
                    aluop    = ALUOP_CMP;
                    pc_write = taken;
                    pc_src   = PC_SRC_BR;
                end else if (is_jal) begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_BR;
                end else if (is_jalr) begin
                    alu_src_b = SRC_B_IMM;
                    pc_write  = 1'b1;
                    pc_src    = PC_SRC_ALU;
                end
            end
            ST_MEM: begin
                mem.mem_req  = 1'b1;
                mem.addr_sel = 1'b1;
                mem.mem_we   = is_store;
            end
            ST_WB: begin
                reg_write = 1'b1;
                if (is_load)               wb_sel = WB_MEM;
                else if (is_jal || is_jalr) wb_sel = WB_PC4;
            end
            default: ;
        endcase
    end

    // Architectural control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            imm_q       <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            imm_q       <= imm_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign imm       = imm_q;
    assign illegal   = illegal_q;
    assign bus_error = bus_error_q;
    assign state_o   = state_q;

endmodule
